rq_ack_initiator: RTL and testbench

- Synthesizable initiator (master) side of the team's request/acknowledge protocol.
- Accepts commands on an upstream valid/ready port and drives req/req_data toward a responder such as the sequential multiplier.
- Captures ack_data on each ack pulse and returns the results in order on a downstream valid/ready port.
- Lets a hardware datapath use req/ack responders, replacing the behavioural send_req-style stimulus.

---
 rtl/rq_ack_initiator_pkg.sv | 18 +
 rtl/rq_ack_initiator_if.sv | 38 +++
 rtl/rq_ack_initiator_rsp_fifo2.sv | 49 ++++
 rtl/rq_ack_initiator.sv | 144 ++++++++++++++
 tb/tb_rq_ack_initiator.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rq_ack_initiator_pkg.sv
// Shared types and constants for the request/acknowledge initiator.
// Holds the FSM state encoding, the response FIFO depth and the issue-credit helper.
package rq_ack_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // A request may only be issued if its result plus everything already owed fits in the FIFO.
    function automatic logic has_credit(input logic [1:0] fifo_cnt, input logic in_flight);
        return ({1'b0, fifo_cnt} + {2'b00, in_flight}) < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/rq_ack_initiator_if.sv
// Bus bundle of the initiator: upstream commands, req/ack link to the responder, downstream results.
// cmd_*/rsp_* transfer on an edge with valid & ready; valid holds with stable data until then. req holds with stable req_data until ack.
interface rq_ack_initiator_if #(
    parameter int REQ_DW = 8,
    parameter int ACK_DW = 8,
    parameter int GAP_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [REQ_DW-1:0] cmd_data;
    logic [GAP_W-1:0]  cmd_gap;
    logic              req;
    logic [REQ_DW-1:0] req_data;
    logic              ack;
    logic [ACK_DW-1:0] ack_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ACK_DW-1:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_data, cmd_gap,
        output cmd_ready,
        output req, req_data,
        input  ack, ack_data,
        output rsp_valid, rsp_data,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_data, cmd_gap,
        input  cmd_ready,
        input  req, req_data,
        output ack, ack_data,
        input  rsp_valid, rsp_data,
        output rsp_ready
    );

endinterface

// File: rtl/rq_ack_initiator_rsp_fifo2.sv
// Two-entry synchronous result FIFO with occupancy count; no write-to-read bypass.
// Pushes into a full FIFO and pops from an empty one are ignored.
module rq_ack_initiator_rsp_fifo2
    import rq_ack_initiator_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] pop_data_o,
    output logic [1:0]    count_o
);

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok    = push_i && (count_q != 2'(FIFO_DEPTH));
    assign pop_ok     = pop_i && (count_q != 2'd0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/rq_ack_initiator.sv
// Initiator side of the req/ack protocol: issues upstream commands as requests and returns
// acknowledged results in order, with optional idle gaps, a request timeout and protocol checking.
module rq_ack_initiator
    import rq_ack_initiator_pkg::*;
#(
    parameter int REQ_DW = 8,
    parameter int ACK_DW = 8,
    parameter int GAP_W  = 4,
    parameter int TO_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    rq_ack_initiator_if.master        bus,
    output state_t                    state_o,
    output logic                      busy_o,
    output logic                      err_timeout_o,
    output logic                      err_proto_o
);

    localparam logic [TO_W-1:0] TO_MAX = '1;

    state_t            state_q, state_d;
    logic [REQ_DW-1:0] req_data_q, req_data_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_proto_q, err_proto_d;

    logic              credit;
    logic              cmd_ready_c;
    logic              accept;
    logic              push;
    logic              pop;
    logic [1:0]        fifo_cnt;
    logic [ACK_DW-1:0] fifo_data;

    always_comb begin
        state_d     = state_q;
        cmd_ready_c = 1'b0;
        accept      = 1'b0;
        push        = 1'b0;
        credit      = has_credit(fifo_cnt, state_q == REQ);
        case (state_q)
            IDLE: begin
                cmd_ready_c = credit;
                if (bus.cmd_valid && credit) begin
                    accept  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.ack) begin
                    push = 1'b1;
                    if (gap_q == '0) begin
                        // Zero gap: the next command rides on this ack so req never drops.
                        if (bus.cmd_valid && credit) begin
                            cmd_ready_c = 1'b1;
                            accept      = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_data_d = (state_d == REQ) ? req_data_q : '0;
        gap_d      = gap_q;
        if (accept) begin
            req_data_d = bus.cmd_data;
            gap_d      = bus.cmd_gap;
        end

        gap_cnt_d = gap_cnt_q;
        if (state_q == REQ && state_d == GAP) begin
            gap_cnt_d = gap_q;
        end else if (state_q == GAP && gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end

        to_cnt_d = '0;
        if (state_q == REQ && !bus.ack) begin
            to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
        end

        err_timeout_d = err_timeout_q | (to_cnt_d == TO_MAX);
        err_proto_d   = err_proto_q | (bus.ack && state_q != REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            req_data_q    <= '0;
            gap_q         <= '0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
            err_proto_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_data_q    <= req_data_d;
            gap_q         <= gap_d;
            gap_cnt_q     <= gap_cnt_d;
            to_cnt_q      <= to_cnt_d;
            err_timeout_q <= err_timeout_d;
            err_proto_q   <= err_proto_d;
        end
    end

    rq_ack_initiator_rsp_fifo2 #(
        .DW (ACK_DW)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (bus.ack_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_data),
        .count_o     (fifo_cnt)
    );

    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.req       = (state_q == REQ);
    assign bus.req_data  = req_data_q;
    assign bus.rsp_valid = (fifo_cnt != 2'd0);
    assign bus.rsp_data  = fifo_data;
    assign state_o       = state_q;
    assign busy_o        = (state_q != IDLE) || (fifo_cnt != 2'd0);
    assign err_timeout_o = err_timeout_q;
    assign err_proto_o   = err_proto_q;

endmodule

// File: tb/tb_rq_ack_initiator.sv
// Bench for rq_ack_initiator: nibble-multiplier responder model, scoreboard on the result port,
// req-hold checker, and one task per scenario.
module tb_rq_ack_initiator;
  import rq_ack_initiator_pkg::*;

  localparam int REQ_DW = 8;
  localparam int ACK_DW = 8;
  localparam int GAP_W  = 4;
  localparam int TO_W   = 4;

  logic   clk;
  logic   rst_n;
  state_t state;
  logic   busy;
  logic   err_timeout;
  logic   err_proto;

  rq_ack_initiator_if #(.REQ_DW(REQ_DW), .ACK_DW(ACK_DW), .GAP_W(GAP_W)) bus ();

  rq_ack_initiator #(
    .REQ_DW (REQ_DW),
    .ACK_DW (ACK_DW),
    .GAP_W  (GAP_W),
    .TO_W   (TO_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .state_o       (state),
    .busy_o        (busy),
    .err_timeout_o (err_timeout),
    .err_proto_o   (err_proto)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [ACK_DW-1:0] exp_q[$];

  logic resp_en;
  int   resp_lat;
  int   r_wait;
  logic prev_req;
  logic prev_ack;
  logic [REQ_DW-1:0] prev_data;
  logic track_low;
  int   req_low_cnt;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [ACK_DW-1:0] mul_model(input logic [REQ_DW-1:0] d);
    logic [7:0] a;
    logic [7:0] b;
    a = {4'h0, d[7:4]};
    b = {4'h0, d[3:0]};
    return a * b;
  endfunction

  // ---------------- responder model (seq_mul DW=4 behaviour) ----------------
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      bus.ack      = 1'b0;
      bus.ack_data = '0;
      r_wait       = 0;
    end else if (bus.ack) begin
      bus.ack      = 1'b0;
      bus.ack_data = '0;
      r_wait       = 0;
    end else if (resp_en && bus.req) begin
      r_wait++;
      if (r_wait >= resp_lat) begin
        bus.ack      = 1'b1;
        bus.ack_data = mul_model(bus.req_data);
      end
    end
  end

  // ---------------- scoreboard and req-hold checker ----------------
  always @(negedge clk) begin
    logic [ACK_DW-1:0] exp_v;
    if (rst_n) begin
      if (bus.cmd_valid && bus.cmd_ready) exp_q.push_back(mul_model(bus.cmd_data));
      if (bus.rsp_valid && bus.rsp_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rsp_unexpected: got rsp_data=%0d, required no response", bus.rsp_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.rsp_data !== exp_v) begin
            mismatched++;
            $display("FAIL rsp_data: got %0d, required %0d", bus.rsp_data, exp_v);
          end
        end
      end
      if (prev_req && !prev_ack) begin
        compared++;
        if (bus.req !== 1'b1 || bus.req_data !== prev_data) begin
          mismatched++;
          $display("FAIL req_hold: got req=%b data=%h, required req=1 data=%h",
                   bus.req, bus.req_data, prev_data);
        end
      end
      if (track_low && !bus.req) req_low_cnt++;
      prev_req  = bus.req;
      prev_ack  = bus.ack;
      prev_data = bus.req_data;
    end else begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [REQ_DW-1:0] d, input logic [GAP_W-1:0] g);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = d;
    bus.cmd_gap   = g;
  endtask

  task automatic wait_accept(input string name);
    logic got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL %s_accept: cmd_ready=0 for 60 cycles, required 1", name);
    end
  endtask

  task automatic wait_ack(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.ack) begin
        seen = 1'b1;
        break;
      end
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL %s_ack_wait: ack=0 for 60 cycles, required 1", name);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_gap = '0;
    bus.rsp_ready = 1'b0; bus.ack = 1'b0; bus.ack_data = '0;
    resp_en = 1'b1; resp_lat = 3; r_wait = 0;
    prev_req = 1'b0; prev_ack = 1'b0; prev_data = '0;
    track_low = 1'b0; req_low_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++; if (bus.req !== 1'b0) begin mismatched++; $display("FAIL rst_req: got %b, required 0", bus.req); end
    compared++; if (bus.req_data !== 8'h00) begin mismatched++; $display("FAIL rst_req_data: got %h, required 00", bus.req_data); end
    compared++; if (bus.rsp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
    compared++; if (bus.rsp_data !== 8'h00) begin mismatched++; $display("FAIL rst_rsp_data: got %h, required 00", bus.rsp_data); end
    compared++; if (err_timeout !== 1'b0 || err_proto !== 1'b0) begin mismatched++; $display("FAIL rst_err: got to=%b proto=%b, required 0 0", err_timeout, err_proto); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy: got %b, required 0", busy); end
    compared++; if (state !== IDLE) begin mismatched++; $display("FAIL rst_state: got %0d, required %0d", state, IDLE); end
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rst_cmd_ready: got %b, required 1", bus.cmd_ready); end
    tick();
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1; resp_lat = 3;
    offer(8'h23, 4'd1);
    wait_accept("single");
    @(negedge clk);
    compared++; if (bus.req !== 1'b1 || bus.req_data !== 8'h23) begin mismatched++; $display("FAIL single_req: got req=%b data=%h, required 1 23", bus.req, bus.req_data); end
    compared++; if (state !== REQ || busy !== 1'b1) begin mismatched++; $display("FAIL single_state: got state=%0d busy=%b, required %0d 1", state, busy, REQ); end
    wait_ack("single");
    @(negedge clk);
    compared++; if (state !== GAP || bus.req !== 1'b0 || bus.req_data !== 8'h00) begin mismatched++; $display("FAIL single_gap: got state=%0d req=%b data=%h, required %0d 0 00", state, bus.req, bus.req_data, GAP); end
    compared++; if (bus.rsp_valid !== 1'b1) begin mismatched++; $display("FAIL single_rsp_valid: got %b, required 1", bus.rsp_valid); end
    @(negedge clk);
    compared++; if (state !== IDLE || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL single_done: got state=%0d rsp_valid=%b busy=%b, required %0d 0 0", state, bus.rsp_valid, busy, IDLE); end
    tick();
  endtask

  task automatic test_back_to_back();
    bus.rsp_ready = 1'b1; resp_lat = 2; req_low_cnt = 0;
    offer(8'h52, 4'd0);
    wait_accept("b2b_0");
    track_low = 1'b1;
    offer(8'h73, 4'd0);
    wait_accept("b2b_1");
    offer(8'h90, 4'd0);
    wait_accept("b2b_2");
    offer(8'h91, 4'd0);
    wait_accept("b2b_3");
    wait_ack("b2b_last");
    track_low = 1'b0;
    compared++; if (req_low_cnt !== 0) begin mismatched++; $display("FAIL b2b_req_low: got %0d low cycles, required 0", req_low_cnt); end
    repeat (3) @(negedge clk);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); end
    compared++; if (state !== IDLE || busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle: got state=%0d busy=%b, required %0d 0", state, busy, IDLE); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.rsp_ready = 1'b0; resp_lat = 3;
    offer(8'h44, 4'd0);
    wait_accept("bp_0");
    offer(8'h12, 4'd0);
    wait_accept("bp_1");
    offer(8'h33, 4'd0);
    wait_ack("bp_second");
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b0 || bus.req !== 1'b0) begin mismatched++; $display("FAIL bp_blocked: got cmd_ready=%b req=%b, required 0 0", bus.cmd_ready, bus.req); end
    compared++; if (bus.rsp_valid !== 1'b1 || busy !== 1'b1 || state !== IDLE) begin mismatched++; $display("FAIL bp_full: got rsp_valid=%b busy=%b state=%0d, required 1 1 %0d", bus.rsp_valid, busy, state, IDLE); end
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b0) begin mismatched++; $display("FAIL bp_still_blocked: got cmd_ready=%b, required 0", bus.cmd_ready); end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    wait_accept("bp_2");
    wait_ack("bp_third");
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL bp_busy: got %b, required 0", busy); end
    tick();
  endtask

  task automatic test_timeout();
    bus.rsp_ready = 1'b1; resp_en = 1'b0; resp_lat = 3;
    offer(8'h5C, 4'd0);
    wait_accept("to");
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 15) begin
        compared++; if (err_timeout !== 1'b0) begin mismatched++; $display("FAIL to_early: got err_timeout=%b at cycle 14, required 0", err_timeout); end
      end
    end
    compared++; if (err_timeout !== 1'b1) begin mismatched++; $display("FAIL to_fire: got err_timeout=%b at cycle 15, required 1", err_timeout); end
    compared++; if (bus.req !== 1'b1 || bus.req_data !== 8'h5C || state !== REQ) begin mismatched++; $display("FAIL to_hold: got req=%b data=%h state=%0d, required 1 5c %0d", bus.req, bus.req_data, state, REQ); end
    resp_en = 1'b1;
    wait_ack("to_release");
    repeat (3) @(negedge clk);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL to_drain: got %0d pending, required 0", exp_q.size()); end
    compared++; if (err_timeout !== 1'b1) begin mismatched++; $display("FAIL to_sticky: got %b, required 1", err_timeout); end
    tick();
  endtask

  task automatic test_proto();
    @(posedge clk);
    #2;
    bus.ack = 1'b1;
    bus.ack_data = 8'hA5;
    @(negedge clk);
    compared++; if (err_proto !== 1'b0) begin mismatched++; $display("FAIL proto_early: got %b, required 0", err_proto); end
    @(negedge clk);
    compared++; if (err_proto !== 1'b1) begin mismatched++; $display("FAIL proto_flag: got %b, required 1", err_proto); end
    compared++; if (bus.rsp_valid !== 1'b0 || state !== IDLE || bus.req !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL proto_ignored: got rsp_valid=%b state=%0d req=%b busy=%b, required 0 %0d 0 0", bus.rsp_valid, state, bus.req, busy, IDLE); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0; resp_lat = 3;
    offer(8'h44, 4'd0);
    wait_accept("rm_0");
    wait_ack("rm_first");
    tick();
    resp_lat = 10;
    offer(8'h12, 4'd0);
    wait_accept("rm_1");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    compared++; if (bus.req !== 1'b0 || bus.req_data !== 8'h00) begin mismatched++; $display("FAIL rm_req: got req=%b data=%h, required 0 00", bus.req, bus.req_data); end
    compared++; if (bus.rsp_valid !== 1'b0 || state !== IDLE || busy !== 1'b0) begin mismatched++; $display("FAIL rm_flush: got rsp_valid=%b state=%0d busy=%b, required 0 %0d 0", bus.rsp_valid, state, busy, IDLE); end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    compared++; if (bus.cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rm_ready: got %b, required 1", bus.cmd_ready); end
    compared++; if (err_timeout !== 1'b0 || err_proto !== 1'b0) begin mismatched++; $display("FAIL rm_err: got to=%b proto=%b, required 0 0", err_timeout, err_proto); end
    tick();
    bus.rsp_ready = 1'b1; resp_lat = 3;
    offer(8'h33, 4'd0);
    wait_accept("rm_2");
    wait_ack("rm_fresh");
    repeat (3) @(negedge clk);
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL rm_drain: got %0d pending, required 0", exp_q.size()); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rm_busy: got %b, required 0", busy); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_proto();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
